// File: rtl/rf_arb_pkg.sv
// Shared defaults and entry layout for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_ARB_AW     = 5;
  localparam int unsigned RF_ARB_DW     = 32;
  localparam int unsigned RF_ARB_DEPTH  = 2;
  localparam int unsigned RF_ARB_STARVE = 8;

  typedef struct packed {
    logic                 valid;
    logic [RF_ARB_AW-1:0] addr;
    logic [RF_ARB_DW-1:0] data;
  } rf_arb_entry_t;

endpackage

// File: rtl/rf_arb_queue.sv
// Result FIFO for the multi-cycle unit, with kill-by-address and
// read-after-write pending lookups against every occupied entry.
module rf_arb_queue
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RF_ARB_DEPTH,
  parameter int unsigned AW    = RF_ARB_AW,
  parameter int unsigned DW    = RF_ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          kill,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd1_pending,
  output logic          rd2_pending,
  output logic          empty,
  output logic          full,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = mem_q[head_q].valid;
  assign head_addr  = mem_q[head_q].addr;
  assign head_data  = mem_q[head_q].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && mem_q[i].valid && mem_q[i].addr == kill_addr) mem_q[i].valid <= 1'b0;
      end
      // Popped slots drop their valid bit so stale data never matches a lookup.
      if (pop) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      if (push) begin
        mem_q[tail_q] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        tail_q        <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    rd1_pending = 1'b0;
    rd2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && mem_q[i].addr == rd1_addr) rd1_pending = 1'b1;
      if (mem_q[i].valid && mem_q[i].addr == rd2_addr) rd2_pending = 1'b1;
    end
    if (rd1_addr == '0) rd1_pending = 1'b0;
    if (rd2_addr == '0) rd2_pending = 1'b0;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register file's single write port: writeback always wins,
// queued multi-cycle results drain into idle slots, starvation raises stall_req.
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_ARB_DEPTH,
  parameter int unsigned STARVE = RF_ARB_STARVE,
  parameter int unsigned AW     = RF_ARB_AW,
  parameter int unsigned DW     = RF_ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_addr,
  input  logic [DW-1:0] md_data,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd1_pending,
  output logic          rd2_pending,
  output logic          stall_req,
  output logic          rf_we,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd3
);

  localparam int unsigned WW = $clog2(STARVE + 1);

  logic          slot_busy;
  logic          push;
  logic          pop;
  logic          q_empty;
  logic          q_full;
  logic          head_valid;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [WW-1:0] wait_q;

  assign slot_busy = wb_we && (wb_addr != '0);
  assign pop       = !slot_busy && !q_empty;
  assign md_ready  = !reset && !q_full;
  // Writes to x0, or results already superseded by the younger WB write, are dropped.
  assign push      = md_valid && md_ready && (md_addr != '0) && !(wb_we && wb_addr == md_addr);
  assign stall_req = (wait_q == WW'(STARVE));

  rf_arb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (md_addr),
    .push_data   (md_data),
    .pop         (pop),
    .kill        (slot_busy),
    .kill_addr   (wb_addr),
    .rd1_addr    (rd1_addr),
    .rd2_addr    (rd2_addr),
    .rd1_pending (rd1_pending),
    .rd2_pending (rd2_pending),
    .empty       (q_empty),
    .full        (q_full),
    .head_valid  (head_valid),
    .head_addr   (head_addr),
    .head_data   (head_data)
  );

  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    if (slot_busy) begin
      rf_we  = 1'b1;
      rf_a3  = wb_addr;
      rf_wd3 = wb_data;
    end else if (!q_empty && head_valid) begin
      rf_we  = 1'b1;
      rf_a3  = head_addr;
      rf_wd3 = head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (q_empty || pop) begin
      wait_q <= '0;
    end else if (slot_busy && wait_q != WW'(STARVE)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [4:0]  rd1_addr;
  logic [4:0]  rd2_addr;
  logic        rd1_pending;
  logic        rd2_pending;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_addr     (md_addr),
    .md_data     (md_data),
    .rd1_addr    (rd1_addr),
    .rd2_addr    (rd2_addr),
    .rd1_pending (rd1_pending),
    .rd2_pending (rd2_pending),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_wd3      (rf_wd3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, ".we"}, 64'(rf_we), 64'(we));
    chk({tag, ".a3"}, 64'(rf_a3), 64'(a));
    chk({tag, ".wd3"}, 64'(rf_wd3), 64'(d));
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; rd1_addr = '0; rd2_addr = '0;
    #2;
    rd1_addr = 5'd5; rd2_addr = 5'd3;
    #1;
    chk("rst.md_ready", 64'(md_ready), 64'd0);
    chk("rst.stall", 64'(stall_req), 64'd0);
    chk("rst.pend1", 64'(rd1_pending), 64'd0);
    chk("rst.pend2", 64'(rd2_pending), 64'd0);
    chk_rf("rst.idle", 1'b0, 5'd0, 32'd0);
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    #1;
    chk_rf("rst.wblive", 1'b1, 5'd2, 32'h55);
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst.md_ready", 64'(md_ready), 64'd1);

    // Single result drains into the next idle slot, never bypassed.
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'hAAAA0001;
    #1;
    chk_rf("md5.nobypass", 1'b0, 5'd0, 32'd0);
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    #1;
    chk_rf("md5.drain", 1'b1, 5'd5, 32'hAAAA0001);
    chk("md5.pend", 64'(rd1_pending), 64'd1);
    tick();
    #1;
    chk_rf("md5.empty", 1'b0, 5'd0, 32'd0);
    chk("md5.pend_clr", 64'(rd1_pending), 64'd0);

    // Two results held off by continuous writeback until starvation.
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h33;
    rd1_addr = 5'd3; rd2_addr = 5'd4;
    tick();
    md_addr = 5'd4; md_data = 32'h44;
    #1;
    chk("starve.ready1", 64'(md_ready), 64'd1);
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    #1;
    chk("starve.ready0", 64'(md_ready), 64'd0);
    chk("starve.pend1", 64'(rd1_pending), 64'd1);
    chk("starve.pend2", 64'(rd2_pending), 64'd1);
    chk_rf("starve.wbwins", 1'b1, 5'd7, 32'h77);
    chk("starve.stall_e1", 64'(stall_req), 64'd0);
    for (int i = 2; i <= 7; i++) tick();
    #1;
    chk("starve.stall_e7", 64'(stall_req), 64'd0);
    tick();
    #1;
    chk("starve.stall_e8", 64'(stall_req), 64'd1);
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk_rf("starve.drain3", 1'b1, 5'd3, 32'h33);
    tick();
    #1;
    chk("starve.stall_clr", 64'(stall_req), 64'd0);
    chk_rf("starve.drain4", 1'b1, 5'd4, 32'h44);
    chk("starve.ready_back", 64'(md_ready), 64'd1);
    chk("starve.pend1_clr", 64'(rd1_pending), 64'd0);
    tick();
    #1;
    chk_rf("starve.empty", 1'b0, 5'd0, 32'd0);
    chk("starve.pend2_clr", 64'(rd2_pending), 64'd0);

    // WAW kill of a queued entry by a younger writeback.
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99; rd1_addr = 5'd9;
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    #1;
    chk("kill.pend_before", 64'(rd1_pending), 64'd1);
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
    #1;
    chk_rf("kill.wb", 1'b1, 5'd9, 32'h1234);
    tick();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("kill.pend_after", 64'(rd1_pending), 64'd0);
    chk_rf("kill.dead_pop", 1'b0, 5'd0, 32'd0);
    tick();
    #1;
    chk_rf("kill.empty", 1'b0, 5'd0, 32'd0);

    // Same-cycle push and writeback to the same register: WB is younger.
    md_valid = 1'b1; md_addr = 5'd6; md_data = 32'h66;
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h60; rd1_addr = 5'd6;
    #1;
    chk_rf("same.wb", 1'b1, 5'd6, 32'h60);
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("same.pend", 64'(rd1_pending), 64'd0);
    chk_rf("same.nodrain", 1'b0, 5'd0, 32'd0);

    // Writes to x0 from either source never reach the register file.
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hDEAD;
    tick();
    md_addr = 5'd10; md_data = 32'hA0;
    #1;
    chk_rf("x0.md", 1'b0, 5'd0, 32'd0);
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
    #1;
    chk_rf("x0.wb_drain", 1'b1, 5'd10, 32'hA0);
    tick();
    #1;
    chk_rf("x0.wb_only", 1'b0, 5'd0, 32'd0);

    // Asynchronous reset mid-queue flushes both entries.
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h70;
    md_valid = 1'b1; md_addr = 5'd11; md_data = 32'hB1;
    rd1_addr = 5'd11; rd2_addr = 5'd12;
    tick();
    md_addr = 5'd12; md_data = 32'hC2;
    tick();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    #1;
    chk("flush.pend_before", 64'(rd1_pending), 64'd1);
    chk("flush.full", 64'(md_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("flush.ready", 64'(md_ready), 64'd0);
    chk("flush.pend1", 64'(rd1_pending), 64'd0);
    chk("flush.pend2", 64'(rd2_pending), 64'd0);
    chk_rf("flush.wblive", 1'b1, 5'd7, 32'h70);
    tick();
    reset = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("flush.ready_back", 64'(md_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk_rf("flush.nowrite", 1'b0, 5'd0, 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the register file's single write port between the pipeline writeback stage and a queue of results from the multi-cycle unit (mult/div, late loads). Writeback always wins. Queued results drain into idle write slots. A starvation counter requests a pipeline bubble when the queue head has waited too long. Pending-destination flags let decode stall on read-after-write (RAW) hazards against queued results. The block sits between the WB stage / multi-cycle unit and the register file's write port (write enable, write address, write data).

## Interface
- DEPTH, 2: queue entries (≥2, power of two)
- STARVE, 8: cycles the head may wait before stall_req asserts (≥1)
- AW, 5: register address width
- DW, 32: data width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_we  in  1  writeback write request
- wb_addr  in  AW  writeback destination
- wb_data  in  DW  writeback data
- md_valid  in  1  multi-cycle result offered
- md_ready  out  1  queue can accept
- md_addr  in  AW  multi-cycle destination
- md_data  in  DW  multi-cycle data
- rd1_addr, rd2_addr  in  AW  decode source registers
- rd1_pending, rd2_pending  out  1  source matches a valid queued entry
- stall_req  out  1  request one bubble in writeback
- rf_we  out  1  to register file write enable
- rf_a3  out  AW  to register file write address
- rf_wd3  out  DW  to register file write data

## Operation
- A write slot is free when !(wb_we && wb_addr!=0).
- Busy slot: rf_we=1, rf_a3=wb_addr, rf_wd3=wb_data. This path is combinational, with zero latency.
- Free slot with a non-empty queue: drive the head entry (rf_we=1) and pop it at the clock edge.
- Free slot with an empty queue: rf_we=0, rf_a3=0, rf_wd3=0.
- Enqueue happens on md_valid && md_ready at the edge.
  - An entry with md_addr==0 is accepted and discarded.
  - An entry is accepted and discarded if wb_we && wb_addr==md_addr in the same cycle, because WB is younger.
- WAW kill: each edge where wb_we && wb_addr!=0, every valid queued entry with a matching address is invalidated.
  - Invalid entries still occupy their slot until popped; a popped invalid entry drives rf_we=0.
- md_ready = !reset && count<DEPTH. Same-cycle pop does not add credit.
- rdN_pending = rdN_addr!=0 && any valid entry address == rdN_addr. Combinational; the incoming md_* is excluded.
- Starvation counter:
  - Increments each cycle the queue is non-empty and the slot is busy.
  - Clears on pop and whenever the queue is empty.
  - Saturates at STARVE.
- stall_req = (wait_cnt==STARVE). The pipeline must present wb_we=0 on the next cycle.
- State: head/tail pointers, count (width clog2(DEPTH+1)), per-entry {valid, addr, data}, and wait_cnt (width clog2(STARVE+1)).

## Timing
- Reset (asynchronous) clears:
  - count=0, pointers=0, valid bits=0, wait_cnt=0
  - therefore stall_req=0, rdN_pending=0, md_ready=0 during reset and 1 after.
  - rf_* follows the WB port; the WB path stays live during reset.
- Enqueue-to-drain latency is at least 1 cycle. There is no bypass from md_* to rf_*.
- Full queue plus a free slot: pop only; md_ready rises on the next cycle.
- Simultaneous push and pop while not full: count is unchanged and pointers advance independently. Pointers wrap modulo DEPTH.
- Reset mid-drain: the queue is flushed and its entries are lost. Writes from a flushed queue are never issued.

## Structure
- Package rf_arb_pkg holds:
  - the AW/DW defaults
  - the entry struct {valid, addr[AW], data[DW]}
  - the DEPTH/STARVE defaults
- Sub-module rf_arb_queue implements:
  - the FIFO with per-entry address compare
  - kill-by-address and pending match outputs
- The top level holds slot arbitration and the starvation counter.

## Test plan
- Reset, then md_valid with addr=5, data=0xAAAA0001, and wb_we=0 throughout → next cycle rf_we=1, rf_a3=5, rf_wd3=0xAAAA0001. The cycle after: queue empty, rf_we=0.
- Two md pushes (addr 3, then 4) while wb_we=1 to addr 7 every cycle → md_ready=0 after the second push, rd1_addr=3 gives rd1_pending=1, and stall_req=1 exactly 8 cycles after the first push. With wb_we then 0: addr 3 drains, then addr 4, and stall_req clears.
- Queue holds addr 9; wb_we=1 to addr 9 with data 0x1234 → the entry is killed, rd1_pending for 9 drops next cycle, and the later free slot shows rf_we=0.
- md_valid addr=6 in the same cycle as wb_we addr=6 → only the WB write appears; pending(6) stays 0.
- md_addr=0 pushed, and wb_we=1 to addr 0 → neither produces rf_we=1. A queued entry drains during the wb addr-0 cycle.
- reset pulsed asynchronously between clock edges with 2 entries queued → md_ready=0 and pending=0 immediately. After release, no queued write ever appears.
